rssb_sequencer: RTL and testbench
=================================

# rssb_sequencer

Parametrised control sequencer for the RSSB (reverse-subtract-and-skip-if-borrow) core, replacing the fixed four-state controller. Drives the same datapath strobes (operand load, accumulator write, memory write, PC update), but talks to memory through a req/ack handshake with wait states. Adds run/single-step control, a halt request, a selectable skip condition, a watchdog on memory accesses and a retired-instruction counter. Sits between the RSSB datapath and the memory port.

## Interface
- `SKIP_MODE`, default 0. Skip condition: 0 = skip on borrow (`neg`); 1 = skip on `neg | zero` (non-positive result).
- `WAIT_MAX`, default 15. Maximum cycles spent waiting for `mem_ack` in one access; 0 disables the watchdog.
- `CNT_W`, default 32. Width of the retired-instruction counter.
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `run`  in  1  level; permits instruction issue
- `step`  in  1  level; when 1, stop in IDLE after each retired instruction
- `halt_req`  in  1  datapath flags a halt instruction; sampled only in BRANCH
- `mem_ack`  in  1  memory completes the current access (read data valid / write accepted)
- `neg`  in  1  borrow flag from subtractor; sampled only in ACC
- `zero`  in  1  zero-result flag; sampled only in ACC
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  1 = write access (valid only with `mem_req`)
- `write_op1`  out  1  load operand register from read data
- `write_acc`  out  1  load accumulator with subtract result
- `write_mem`  out  1  write-commit strobe
- `write_pc`  out  1  PC update strobe
- `pc_skip`  out  1  with `write_pc`: 1 = PC+2, 0 = PC+1
- `busy`  out  1  1 in FETCH, ACC, STORE, BRANCH
- `halted`  out  1  1 in HALTED
- `fault`  out  1  1 in FAULT
- `instr_count`  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States: IDLE, FETCH, ACC, STORE, BRANCH, HALTED, FAULT.
- Every output defaults to 0 in every state unless listed for that state below.
- **IDLE:** if `run` = 1, go to FETCH; otherwise stay.
- **FETCH:**
  - `mem_req` = 1, `mem_we` = 0.
  - On `mem_ack`: `write_op1` = 1 in that same cycle (Mealy), then go to ACC.
- **ACC:** `write_acc` = 1 for exactly one cycle. Latch `skip_q` = `neg` (SKIP_MODE 0) or `neg | zero` (SKIP_MODE 1). Go to STORE.
- **STORE:**
  - `mem_req` = 1, `mem_we` = 1.
  - On `mem_ack`: `write_mem` = 1 in that same cycle, then go to BRANCH.
- **BRANCH:**
  - `write_pc` = 1, `pc_skip` = `skip_q`; `instr_count` increments.
  - Next state, in priority order: `halt_req` → HALTED; else `step` or `!run` → IDLE; else FETCH.
- **HALTED:** `halted` = 1. Terminal; only `rst` leaves it.
- **FAULT:** `fault` = 1, `mem_req` = 0. Terminal; only `rst` leaves it.
- **Watchdog:**
  - A wait counter clears on entry to FETCH or STORE and increments each cycle without `mem_ack`.
  - If it reaches WAIT_MAX without ack, go to FAULT next cycle; no strobe is issued.
  - An ack arriving in the same cycle as the limit wins.
- `mem_req` stays asserted, with stable `mem_we`, until ack; it is never withdrawn early except by `rst` or FAULT.
- `mem_ack` in any other state is ignored.
- Dropping `run` mid-instruction does not abort: the instruction completes through BRANCH, then the sequencer goes to IDLE.
- `step` is level-sensitive: holding `run` = 1 with `step` = 1 executes one instruction per IDLE visit, i.e. IDLE→FETCH on the next cycle.

## Timing
- Reset: asynchronous.
  - All outputs 0, `instr_count` = 0, `skip_q` = 0, wait counter 0, state IDLE.
  - Applies immediately, including mid-access; `mem_req` drops in the same cycle `rst` rises.
- Minimum instruction (ack in the first cycle of each access): 4 cycles (FETCH, ACC, STORE, BRANCH).
- Each wait cycle without ack adds one cycle.
- IDLE→FETCH costs 1 cycle.
- `instr_count` reflects the increment on the clock edge that ends BRANCH.
- `neg`/`zero` must be valid in the ACC cycle.
- `halt_req` must be valid in the BRANCH cycle.
- Counter wrap: all-ones + 1 = 0, with no flag.

## Structure
- Package `rssb_pkg`:
  - `rssb_state_t`, a 3-bit enum of the seven states.
  - Constants `SKIP_BORROW` = 0 and `SKIP_NONPOS` = 1.
- Sub-module `rssb_wait_timer`: clear/enable wait counter with parametrised limit and a `expired` output. Instantiated once.
- The FSM plus the `instr_count` register live in `rssb_sequencer`.

## Test plan
- Reset, then `run` = 1 with immediate acks, `neg` = 1 → 4-cycle instruction, `pc_skip` = 1 in BRANCH, `instr_count` = 1.
- FETCH ack delayed 3 cycles, `neg` = 0 → `mem_req` held 4 cycles, `write_op1` one pulse on the ack cycle, `pc_skip` = 0, instruction takes 7 cycles.
- SKIP_MODE = 1 with `neg` = 0, `zero` = 1 → `pc_skip` = 1; repeat with SKIP_MODE = 0 → `pc_skip` = 0.
- WAIT_MAX = 4, no ack in STORE → `fault` = 1 after 4 wait cycles, `write_mem` never asserted; `rst` pulse → all outputs 0, state IDLE.
- `step` = 1, `run` = 1 for 3 instructions → returns to IDLE between instructions, `instr_count` = 3; `halt_req` = 1 in third BRANCH → `halted` = 1, stays halted despite `run`.
- `rst` asserted mid-FETCH with `mem_req` = 1 → `mem_req` = 0 in the same cycle, `instr_count` = 0; with CNT_W = 4, 16 instructions → `instr_count` wraps to 0.

Source files
------------

// File: rtl/rssb_sequencer_pkg.sv
// Shared types and constants for the RSSB control sequencer.
// Imported by the sequencer top and its wait timer.
package rssb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ACC    = 3'd2,
        ST_STORE  = 3'd3,
        ST_BRANCH = 3'd4,
        ST_HALTED = 3'd5,
        ST_FAULT  = 3'd6
    } rssb_state_t;

    localparam int SKIP_BORROW = 0;
    localparam int SKIP_NONPOS = 1;

    // Skip decision taken from the subtractor flags in the ACC cycle.
    function automatic logic skip_cond(input int mode, input logic neg, input logic zero);
        return (mode == SKIP_NONPOS) ? (neg | zero) : neg;
    endfunction

endpackage

// File: rtl/rssb_sequencer_if.sv
// Memory req/ack port between the sequencer and the memory.
// mem_req holds, with stable mem_we, until the cycle mem_ack is high; that cycle completes the access.
interface rssb_sequencer_if;

    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ack
    );

endinterface

// File: rtl/rssb_sequencer_wait_timer.sv
// Wait-state counter for one memory access; expired pulses on the
// WAIT_MAX-th consecutive cycle without an ack. WAIT_MAX = 0 never expires.
module rssb_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] LIMIT = (WAIT_MAX > 0) ? CW'(WAIT_MAX - 1) : '0;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // The cycle that would bring the count to WAIT_MAX is the expiring one.
    assign expired = (WAIT_MAX != 0) && enable && (cnt_q == LIMIT);

endmodule

// File: rtl/rssb_sequencer.sv
// RSSB control sequencer: issues datapath strobes and drives the memory
// req/ack port, with run/step control, halt, watchdog and retired-instruction count.
module rssb_sequencer
    import rssb_pkg::*;
#(
    parameter int SKIP_MODE = SKIP_BORROW,
    parameter int WAIT_MAX  = 15,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic               halt_req,
    input  logic               neg,
    input  logic               zero,
    rssb_sequencer_if.master   mem,
    output logic               write_op1,
    output logic               write_acc,
    output logic               write_mem,
    output logic               write_pc,
    output logic               pc_skip,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   instr_count,
    output rssb_state_t        state_dbg
);

    rssb_state_t      state_q;
    logic             skip_q;
    logic [CNT_W-1:0] count_q;
    logic             wait_active;
    logic             wait_expired;

    assign wait_active = (state_q == ST_FETCH) || (state_q == ST_STORE);

    rssb_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!wait_active),
        .enable  (wait_active && !mem.mem_ack),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            skip_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem.mem_ack)       state_q <= ST_ACC;
                    else if (wait_expired) state_q <= ST_FAULT;
                end
                ST_ACC: begin
                    skip_q  <= skip_cond(SKIP_MODE, neg, zero);
                    state_q <= ST_STORE;
                end
                ST_STORE: begin
                    if (mem.mem_ack)       state_q <= ST_BRANCH;
                    else if (wait_expired) state_q <= ST_FAULT;
                end
                ST_BRANCH: begin
                    count_q <= count_q + CNT_W'(1);
                    if (halt_req)          state_q <= ST_HALTED;
                    else if (step || !run) state_q <= ST_IDLE;
                    else                   state_q <= ST_FETCH;
                end
                ST_HALTED: state_q <= ST_HALTED;
                ST_FAULT:  state_q <= ST_FAULT;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register, so reset clears them
    // asynchronously; op1/mem commit strobes follow the ack in the same cycle.
    assign mem.mem_req = wait_active;
    assign mem.mem_we  = (state_q == ST_STORE);
    assign write_op1   = (state_q == ST_FETCH) && mem.mem_ack;
    assign write_acc   = (state_q == ST_ACC);
    assign write_mem   = (state_q == ST_STORE) && mem.mem_ack;
    assign write_pc    = (state_q == ST_BRANCH);
    assign pc_skip     = (state_q == ST_BRANCH) && skip_q;
    assign busy        = wait_active || (state_q == ST_ACC) || (state_q == ST_BRANCH);
    assign halted      = (state_q == ST_HALTED);
    assign fault       = (state_q == ST_FAULT);
    assign instr_count = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_rssb_sequencer.sv
// Two sequencers in lockstep: dut0 (borrow skip, WAIT_MAX 15, 32-bit count)
// and dut1 (non-positive skip, WAIT_MAX 4, 4-bit count).
module tb_rssb_sequencer;
    import rssb_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0, step = 1'b0, halt_req = 1'b0, neg = 1'b0, zero = 1'b0, mem_ack = 1'b0;

    always #5 clk = ~clk;

    rssb_sequencer_if mif0 ();
    rssb_sequencer_if mif1 ();
    assign mif0.mem_ack = mem_ack;
    assign mif1.mem_ack = mem_ack;

    logic op1_0, acc_0, wm_0, pc_0, sk_0, busy_0, hlt_0, flt_0;
    logic op1_1, acc_1, wm_1, pc_1, sk_1, busy_1, hlt_1, flt_1;
    logic [31:0] cnt_0;
    logic [3:0]  cnt_1;
    rssb_state_t st_0, st_1;

    rssb_sequencer #(.SKIP_MODE(SKIP_BORROW), .WAIT_MAX(15), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
        .neg(neg), .zero(zero), .mem(mif0),
        .write_op1(op1_0), .write_acc(acc_0), .write_mem(wm_0), .write_pc(pc_0),
        .pc_skip(sk_0), .busy(busy_0), .halted(hlt_0), .fault(flt_0),
        .instr_count(cnt_0), .state_dbg(st_0)
    );

    rssb_sequencer #(.SKIP_MODE(SKIP_NONPOS), .WAIT_MAX(4), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
        .neg(neg), .zero(zero), .mem(mif1),
        .write_op1(op1_1), .write_acc(acc_1), .write_mem(wm_1), .write_pc(pc_1),
        .pc_skip(sk_1), .busy(busy_1), .halted(hlt_1), .fault(flt_1),
        .instr_count(cnt_1), .state_dbg(st_1)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic [1:0] exp_q[$];  // {expected pc_skip dut0, expected pc_skip dut1}

    // Output vector order: req, we, op1, acc, wmem, wpc, busy, halted, fault
    function automatic logic [8:0] obs0();
        return {mif0.mem_req, mif0.mem_we, op1_0, acc_0, wm_0, pc_0, busy_0, hlt_0, flt_0};
    endfunction

    function automatic logic [8:0] obs1();
        return {mif1.mem_req, mif1.mem_we, op1_1, acc_1, wm_1, pc_1, busy_1, hlt_1, flt_1};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction starting in its FETCH cycle; fw/sw are the
    // number of wait cycles before ack in FETCH/STORE.
    task automatic run_instr(input int fw, input int sw, input logic n, input logic z, input logic h);
        logic [8:0] e;
        logic [1:0] ep;
        exp_q.push_back({n, n | z});
        for (int i = 0; i <= fw; i++) begin
            mem_ack = (i == fw);
            #1;
            e = {1'b1, 1'b0, (i == fw), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs0() !== e) begin failures++; $display("FAIL fetch dut0 cyc=%0d got=%b exp=%b", i, obs0(), e); end
            checks++;
            if (obs1() !== e) begin failures++; $display("FAIL fetch dut1 cyc=%0d got=%b exp=%b", i, obs1(), e); end
            tick();
        end
        mem_ack = 1'b0; neg = n; zero = z;
        #1;
        e = 9'b000100100;
        checks++;
        if (obs0() !== e) begin failures++; $display("FAIL acc dut0 got=%b exp=%b", obs0(), e); end
        checks++;
        if (obs1() !== e) begin failures++; $display("FAIL acc dut1 got=%b exp=%b", obs1(), e); end
        tick();
        neg = 1'b0; zero = 1'b0;
        for (int i = 0; i <= sw; i++) begin
            mem_ack = (i == sw);
            #1;
            e = {1'b1, 1'b1, 1'b0, 1'b0, (i == sw), 1'b0, 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs0() !== e) begin failures++; $display("FAIL store dut0 cyc=%0d got=%b exp=%b", i, obs0(), e); end
            checks++;
            if (obs1() !== e) begin failures++; $display("FAIL store dut1 cyc=%0d got=%b exp=%b", i, obs1(), e); end
            tick();
        end
        mem_ack = 1'b0; halt_req = h;
        #1;
        e = 9'b000001100;
        checks++;
        if (obs0() !== e) begin failures++; $display("FAIL branch dut0 got=%b exp=%b", obs0(), e); end
        checks++;
        if (obs1() !== e) begin failures++; $display("FAIL branch dut1 got=%b exp=%b", obs1(), e); end
        ep = exp_q.pop_front();
        checks++;
        if (sk_0 !== ep[1]) begin failures++; $display("FAIL pc_skip dut0 got=%b exp=%b", sk_0, ep[1]); end
        checks++;
        if (sk_1 !== ep[0]) begin failures++; $display("FAIL pc_skip dut1 got=%b exp=%b", sk_1, ep[0]); end
        tick();
        halt_req = 1'b0;
        exp_cnt++;
        checks++;
        if (cnt_0 !== 32'(exp_cnt)) begin failures++; $display("FAIL count dut0 got=%0d exp=%0d", cnt_0, exp_cnt); end
        checks++;
        if (cnt_1 !== 4'(exp_cnt)) begin failures++; $display("FAIL count dut1 got=%0d exp=%0d", cnt_1, 4'(exp_cnt)); end
    endtask

    task automatic expect_state(input string name, input rssb_state_t s);
        checks++;
        if (st_0 !== s) begin failures++; $display("FAIL %s state dut0 got=%0d exp=%0d", name, st_0, s); end
        checks++;
        if (st_1 !== s) begin failures++; $display("FAIL %s state dut1 got=%0d exp=%0d", name, st_1, s); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; mem_ack = 1'b0;
        halt_req = 1'b0; neg = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({obs0(), sk_0} !== 10'd0) begin failures++; $display("FAIL reset outs dut0 got=%b exp=0", {obs0(), sk_0}); end
        checks++;
        if ({obs1(), sk_1} !== 10'd0) begin failures++; $display("FAIL reset outs dut1 got=%b exp=0", {obs1(), sk_1}); end
        checks++;
        if (cnt_0 !== 32'd0 || cnt_1 !== 4'd0) begin failures++; $display("FAIL reset count got=%0d/%0d exp=0", cnt_0, cnt_1); end
        expect_state("reset", ST_IDLE);
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
    endtask

    task automatic test_basic();
        run = 1'b1; step = 1'b1;
        tick();
        run_instr(0, 0, 1'b1, 1'b0, 1'b0);
        expect_state("basic_end", ST_IDLE);
    endtask

    task automatic test_fetch_wait();
        tick();
        run_instr(3, 0, 1'b0, 1'b0, 1'b0);
        expect_state("fetch_wait_end", ST_IDLE);
    endtask

    task automatic test_skip_mode();
        tick();
        run_instr(0, 0, 1'b0, 1'b1, 1'b0);
        expect_state("skip_zero_end", ST_IDLE);
        tick();
        run_instr(0, 1, 1'b0, 1'b0, 1'b0);
        expect_state("skip_none_end", ST_IDLE);
    endtask

    task automatic test_back_to_back();
        step = 1'b0;
        tick();
        run_instr(0, 0, 1'b1, 1'b0, 1'b0);
        expect_state("b2b_refetch", ST_FETCH);
        run = 1'b0;
        run_instr(1, 2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_state("b2b_idle", ST_IDLE);
            tick();
        end
    endtask

    task automatic test_step_halt();
        test_reset();
        run = 1'b1; step = 1'b1;
        tick();
        run_instr(0, 0, 1'b1, 1'b1, 1'b0);
        expect_state("step1", ST_IDLE);
        tick();
        run_instr(2, 1, 1'b0, 1'b0, 1'b0);
        expect_state("step2", ST_IDLE);
        tick();
        run_instr(0, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            mem_ack = i[0];
            #1;
            checks++;
            if (obs0() !== 9'b000000010 || obs1() !== 9'b000000010) begin
                failures++; $display("FAIL halted outs got=%b/%b exp=000000010", obs0(), obs1());
            end
            expect_state("halted", ST_HALTED);
            tick();
        end
        mem_ack = 1'b0;
        checks++;
        if (cnt_0 !== 32'd3) begin failures++; $display("FAIL halted count got=%0d exp=3", cnt_0); end
    endtask

    task automatic test_watchdog();
        test_reset();
        run = 1'b1; step = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs1() !== 9'b110000100) begin failures++; $display("FAIL wd wait dut1 cyc=%0d got=%b exp=110000100", i, obs1()); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1;
            checks++;
            if (obs1() !== 9'b000000001) begin failures++; $display("FAIL wd fault dut1 cyc=%0d got=%b exp=000000001", i, obs1()); end
            checks++;
            if (obs0() !== {1'b1, 1'b1, 1'b0, 1'b0, (i == 3), 1'b0, 1'b1, 1'b0, 1'b0}) begin
                failures++; $display("FAIL wd store dut0 cyc=%0d got=%b", i, obs0());
            end
            checks++;
            if (st_1 !== ST_FAULT) begin failures++; $display("FAIL wd state dut1 got=%0d exp=%0d", st_1, ST_FAULT); end
            tick();
        end
        mem_ack = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (obs0() !== 9'd0 || obs1() !== 9'd0) begin failures++; $display("FAIL wd rst outs got=%b/%b exp=0", obs0(), obs1()); end
        expect_state("wd_rst", ST_IDLE);
        test_reset();
    endtask

    task automatic test_reset_mid_fetch();
        run = 1'b1; step = 1'b1;
        tick();
        run_instr(0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mif0.mem_req !== 1'b1 || mif1.mem_req !== 1'b1) begin
            failures++; $display("FAIL midfetch req got=%b/%b exp=1", mif0.mem_req, mif1.mem_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mif0.mem_req !== 1'b0 || mif1.mem_req !== 1'b0) begin
            failures++; $display("FAIL midfetch req after rst got=%b/%b exp=0", mif0.mem_req, mif1.mem_req);
        end
        checks++;
        if (cnt_0 !== 32'd0 || cnt_1 !== 4'd0) begin failures++; $display("FAIL midfetch count got=%0d/%0d exp=0", cnt_0, cnt_1); end
        expect_state("midfetch_rst", ST_IDLE);
        test_reset();
    endtask

    task automatic test_wrap();
        run = 1'b1; step = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k == 15) run = 1'b0;
            run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        expect_state("wrap_end", ST_IDLE);
        checks++;
        if (cnt_1 !== 4'd0 || cnt_0 !== 32'd16) begin
            failures++; $display("FAIL wrap count got=%0d/%0d exp=16/0", cnt_0, cnt_1);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_fetch_wait();
        test_skip_mode();
        test_back_to_back();
        test_step_halt();
        test_watchdog();
        test_reset_mid_fetch();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
